// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-4 Booth multiplier.
// One Booth digit is retired per clock, so the latency is a fixed WIDTH/2+1
// cycles after the launch edge. Operands are extended to WIDTH+2 bits
// (sign or zero, depending on signed_mode). This lets one datapath produce
// exact signed and unsigned products.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // Extended operand width, accumulator width, digit count, counter width.
  localparam int EXT_W = WIDTH + 2;
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam int N     = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r;
  // The multiplicand is kept sign-extended to the accumulator width.
  // It is pre-shifted by 2*i, so the Booth term needs no variable shifter.
  logic [ACC_W-1:0]   mcand_r;
  logic [EXT_W-1:0]   mplier_r;
  logic               prev_r;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] product_r;

  logic [ACC_W-1:0]   a_ext_s;
  logic [EXT_W-1:0]   b_ext_s;
  logic [ACC_W-1:0]   term_s;
  logic [ACC_W-1:0]   acc_next_s;
  logic               last_digit_s;

  // Map the Booth digit {b1, b0, prev} to the signed multiple of the shifted
  // multiplicand: {0, +A, +A, +2A, -2A, -A, -A, 0}.
  function automatic logic [ACC_W-1:0] booth_term(
    input logic [2:0]       digit,
    input logic [ACC_W-1:0] m
  );
    logic [ACC_W-1:0] m2;
    m2 = {m[ACC_W-2:0], 1'b0};
    case (digit)
      3'b000:  booth_term = {ACC_W{1'b0}};
      3'b001:  booth_term = m;
      3'b010:  booth_term = m;
      3'b011:  booth_term = m2;
      3'b100:  booth_term = ~m2 + {{(ACC_W-1){1'b0}}, 1'b1};
      3'b101:  booth_term = ~m + {{(ACC_W-1){1'b0}}, 1'b1};
      3'b110:  booth_term = ~m + {{(ACC_W-1){1'b0}}, 1'b1};
      3'b111:  booth_term = {ACC_W{1'b0}};
      default: booth_term = {ACC_W{1'b0}};
    endcase
  endfunction

  // Operand extension at launch, plus the current digit's partial-product add.
  always_comb begin
    a_ext_s      = {ACC_W{1'b0}};
    b_ext_s      = {EXT_W{1'b0}};
    term_s       = {ACC_W{1'b0}};
    acc_next_s   = {ACC_W{1'b0}};
    last_digit_s = 1'b0;
    if (signed_mode) begin
      a_ext_s = {{(ACC_W-WIDTH){a[WIDTH-1]}}, a};
      b_ext_s = {{2{b[WIDTH-1]}}, b};
    end else begin
      a_ext_s = {{(ACC_W-WIDTH){1'b0}}, a};
      b_ext_s = {2'b00, b};
    end
    term_s       = booth_term({mplier_r[1:0], prev_r}, mcand_r);
    acc_next_s   = acc_r + term_s;
    last_digit_s = (cnt_r == CNT_W'(1));
  end

  // Control FSM and datapath. The product is written only on the completion
  // edge, so partial sums never reach the output.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r   <= ST_IDLE;
      mcand_r   <= {ACC_W{1'b0}};
      mplier_r  <= {EXT_W{1'b0}};
      prev_r    <= 1'b0;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mcand_r  <= a_ext_s;
            mplier_r <= b_ext_s;
            prev_r   <= 1'b0;
            acc_r    <= {ACC_W{1'b0}};
            cnt_r    <= CNT_W'(N);
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r    <= acc_next_s;
          mcand_r  <= {mcand_r[ACC_W-3:0], 2'b00};
          mplier_r <= {{2{mplier_r[EXT_W-1]}}, mplier_r[EXT_W-1:2]};
          prev_r   <= mplier_r[1];
          cnt_r    <= cnt_r - CNT_W'(1);
          if (last_digit_s) begin
            product_r <= acc_next_s[2*WIDTH-1:0];
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            done_r    <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH = 32, 4 and 8.
// Launches push their expected product (from plain integer arithmetic) into a
// per-instance queue; a negedge monitor pops and compares on every done.
module tb_booth_mult_seq;

  localparam int WW [3] = '{32, 4, 8};

  typedef struct {
    logic [63:0] prod;
    int          launch;
  } sb_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic [2:0]  sm_v = 3'b000;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [63:0] prod_v [3];
  logic [63:0] p32;
  logic [7:0]  p4;
  logic [15:0] p8;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  sb_t         q [3][$];
  logic [63:0] last_prod [3];
  logic [2:0]  prev_done = 3'b000;
  logic [2:0]  running = 3'b000;
  int          last_launch [3];

  booth_mult_seq #(.WIDTH(32)) u32 (
    .clk(clk), .clr(clr), .start(start_v[0]), .signed_mode(sm_v[0]),
    .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]), .product(p32));
  booth_mult_seq #(.WIDTH(4)) u4 (
    .clk(clk), .clr(clr), .start(start_v[1]), .signed_mode(sm_v[1]),
    .a(a_v[1][3:0]), .b(b_v[1][3:0]), .busy(busy_v[1]), .done(done_v[1]), .product(p4));
  booth_mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .clr(clr), .start(start_v[2]), .signed_mode(sm_v[2]),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .busy(busy_v[2]), .done(done_v[2]), .product(p8));

  assign prod_v[0] = p32;
  assign prod_v[1] = {56'd0, p4};
  assign prod_v[2] = {48'd0, p8};

  always #5 clk = ~clk;

  // Edge counter: after rising edge e, cyc == e.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int n_of(input int i);
    return WW[i] / 2 + 1;
  endfunction

  // Reference: extend both operands to 64 bits, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic sm,
                                          input logic [31:0] x, input logic [31:0] y);
    logic [63:0] m, xe, ye, p;
    m  = (64'd1 << w) - 64'd1;
    xe = {32'd0, x} & m;
    ye = {32'd0, y} & m;
    if (sm && x[w-1]) xe = xe | ~m;
    if (sm && y[w-1]) ye = ye | ~m;
    p = xe * ye;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  // Drive one start pulse; the model accepts it only if the unit is idle.
  task automatic launch(input int i, input logic sm, input logic [31:0] x, input logic [31:0] y);
    sb_t e;
    start_v[i] = 1'b1;
    sm_v[i]    = sm;
    a_v[i]     = x;
    b_v[i]     = y;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    if (!running[i] || cyc > last_launch[i] + n_of(i)) begin
      e.prod   = ref_mul(WW[i], sm, x, y);
      e.launch = cyc;
      q[i].push_back(e);
      running[i]     = 1'b1;
      last_launch[i] = cyc;
    end
    sm_v[i] = 1'($urandom);
    a_v[i]  = $urandom;
    b_v[i]  = $urandom;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until every scoreboard queue has drained.
  task automatic drain(input int bound);
    int c;
    c = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && c < bound) begin
      @(negedge clk);
      #1;
      c++;
    end
    checks++;
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0",
               q[0].size() + q[1].size() + q[2].size());
      for (int i = 0; i < 3; i++) q[i].delete();
    end
  endtask

  task automatic directed(input logic sm, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp);
    launch(0, sm, x, y);
    drain(100);
    checks++;
    if (prod_v[0] !== exp) begin
      errors++;
      $display("FAIL directed_const got=%h required=%h", prod_v[0], exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      last_prod[i] = 64'd0;
    end
    running   = 3'b000;
    prev_done = 3'b000;
  endtask

  // Monitor: protocol checks every cycle, scoreboard compare on each done.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!clr) begin
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (busy_v[i] && done_v[i]) begin
            errors++;
            $display("FAIL busy_and_done inst=%0d got=1 required=0", i);
          end
          if (done_v[i]) begin
            checks++;
            if (prev_done[i]) begin
              errors++;
              $display("FAIL done_twice inst=%0d got=1 required=0", i);
            end
            if (q[i].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done inst=%0d got=1 required=0", i);
            end else begin
              e = q[i].pop_front();
              checks++;
              if (prod_v[i] !== e.prod) begin
                errors++;
                $display("FAIL product inst=%0d got=%h required=%h", i, prod_v[i], e.prod);
              end
              checks++;
              if (cyc - e.launch != n_of(i)) begin
                errors++;
                $display("FAIL latency inst=%0d got=%0d required=%0d", i, cyc - e.launch, n_of(i));
              end
              last_prod[i] = e.prod;
            end
          end else begin
            checks++;
            if (prod_v[i] !== last_prod[i]) begin
              errors++;
              $display("FAIL product_hold inst=%0d got=%h required=%h", i, prod_v[i], last_prod[i]);
            end
          end
          prev_done[i] = done_v[i];
        end
      end else begin
        prev_done = 3'b000;
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      a_v[i] = 32'd0;
      b_v[i] = 32'd0;
      last_launch[i] = 0;
    end
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || prod_v[i] !== 64'd0) begin
        errors++;
        $display("FAIL reset_state inst=%0d got busy=%b done=%b prod=%h required 0/0/0",
                 i, busy_v[i], done_v[i], prod_v[i]);
      end
    end
    gap(3);
    clr = 1'b0;

    // Directed WIDTH=32 cases with known results.
    directed(1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    directed(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    directed(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    directed(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    directed(1'b0, 32'h1234_5678, 32'd0, 64'd0);

    // start mid-RUN must be ignored; first result unchanged.
    launch(0, 1'b1, 32'd1234567, 32'hFFFF_F000);
    gap(4);
    launch(0, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    drain(100);
    checks++;
    if (prod_v[0] !== ref_mul(32, 1'b1, 32'd1234567, 32'hFFFF_F000)) begin
      errors++;
      $display("FAIL ignored_start got=%h required=%h", prod_v[0],
               ref_mul(32, 1'b1, 32'd1234567, 32'hFFFF_F000));
    end

    // Back-to-back: second start lands in the done cycle.
    launch(0, 1'b1, 32'h0001_0001, 32'h7FFF_FFFF);
    gap(n_of(0));
    launch(0, 1'b0, 32'hABCD_0123, 32'h0000_FFFF);
    gap(n_of(0));
    launch(0, 1'b1, 32'h8000_0001, 32'h0000_0003);
    drain(200);

    // Random WIDTH=32 traffic with random gaps (some starts land mid-RUN).
    for (int k = 0; k < 40; k++) begin
      launch(0, 1'($urandom), $urandom, $urandom);
      gap($urandom_range(0, 20));
    end
    drain(200);

    // Asynchronous clear five cycles into RUN.
    launch(0, 1'b1, 32'h0BAD_F00D, 32'h1357_9BDF);
    gap(5);
    #3;
    clr = 1'b1;
    #1;
    checks++;
    if (busy_v[0] !== 1'b0 || prod_v[0] !== 64'd0) begin
      errors++;
      $display("FAIL mid_clear got busy=%b prod=%h required busy=0 prod=0", busy_v[0], prod_v[0]);
    end
    model_reset();
    gap(2);
    clr = 1'b0;
    gap(25);
    directed(1'b0, 32'h0000_FFFF, 32'h0001_0000, 64'h0000_0000_FFFF_0000);

    // WIDTH=4: every operand pair in both modes, back-to-back.
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          launch(1, 1'(m), 32'(x), 32'(y));
          gap(n_of(1));
        end
    drain(100);

    // WIDTH=8: corner pairs exhaustively, then random pairs.
    begin
      logic [31:0] cv [6];
      cv = '{32'h00, 32'h01, 32'h7F, 32'h80, 32'hFF, 32'h55};
      for (int m = 0; m < 2; m++)
        for (int x = 0; x < 6; x++)
          for (int y = 0; y < 6; y++) begin
            launch(2, 1'(m), cv[x], cv[y]);
            gap(n_of(2));
          end
    end
    for (int k = 0; k < 1500; k++) begin
      launch(2, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255));
      gap(n_of(2));
    end
    drain(100);
    gap(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
